udp_tx_machine: RTL
===================

# udp_tx_machine

Transmit-side counterpart of the UDP receive path: accepts a 32-bit payload word and emits it to the MAC TX byte interface as one Ethernet II / IPv4 / UDP frame. Headers come from parameters; the IPv4 header checksum is computed on the fly and the IP ID increments per frame. The MAC adds preamble, pads to 60 bytes and appends FCS; this block produces bytes 0..45 only.

## Interface
- MY_HWADDR, 48'h98_5a_eb_dd_1c_65, source MAC
- DST_HWADDR, 48'hff_ff_ff_ff_ff_ff, destination MAC
- MY_IP, 32'hc0a80205, source IP (192.168.2.5)
- DST_IP, 32'hc0a80201, destination IP (192.168.2.1)
- MY_PORT, 16'h4e50, UDP source port
- DST_PORT, 16'h4e50, UDP destination port
- clk  in  1  single clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- tx_udp_req  in  1  payload valid; held with data until ack
- tx_udp_data  in  32  payload, byte [31:24] sent first
- tx_udp_ack  out  1  one-cycle pulse: payload latched
- tx_udp_done  out  1  one-cycle pulse: last byte accepted by MAC
- tx_busy  out  1  high in any state except IDLE
- tx_vld  out  1  byte valid toward MAC
- tx_rdy  in  1  MAC accepts byte when tx_vld & tx_rdy
- tx_last  out  1  marks byte 45
- tx_addr  out  11  byte index in frame (0..45)
- tx_data  out  8  frame byte

## Operation
- States: IDLE, CSUM, SEND, DONE (one-hot).
- IDLE: tx_udp_ack = tx_udp_req (combinational); on req, latch payload, clear checksum accumulator, go to CSUM.
- CSUM: 10 cycles; 4-bit counter walks header words 4500, 0020, ip_id, 0000, 4011, 0000, MY_IP[31:16], MY_IP[15:0], DST_IP[31:16], DST_IP[15:0]; 17-bit accumulate with end-around carry each cycle; after word 9, store csum = ~sum[15:0]; go to SEND.
- SEND: tx_vld=1; tx_addr advances only on tx_vld & tx_rdy. Byte map: 0-5 DST_HWADDR (MSB first); 6-11 MY_HWADDR; 12-13 08 00; 14 45; 15 00; 16-17 00 20 (total length 32); 18-19 ip_id; 20-21 00 00; 22 40; 23 11; 24-25 csum; 26-29 MY_IP; 30-33 DST_IP; 34-35 MY_PORT; 36-37 DST_PORT; 38-39 00 0c (UDP length 12); 40-41 00 00 (no UDP checksum); 42-45 payload.
- tx_last = SEND & tx_addr==45. On its acceptance: go DONE, ip_id <= ip_id+1 (16-bit wrap ffff->0000).
- DONE: one cycle; tx_udp_done=1; go IDLE. New req not accepted in DONE.
- req while busy: ignored, no ack; requester keeps req high.
- tx_udp_data changes after ack have no effect on the current frame.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, ip_id 0, tx_addr 0, all outputs 0 (tx_udp_ack follows req only once in IDLE after release).
- Reset mid-frame: tx_vld drops next cycle, no tx_last/done, ip_id unchanged; the MAC discards the partial frame.
- Req sampled in cycle N: ack in N; CSUM N+1..N+10; tx_vld from N+11 with tx_addr 0.
- Zero backpressure: 46 bytes in N+11..N+56, tx_last in N+56, tx_udp_done in N+57, next ack earliest N+58.
- tx_rdy low: tx_data/tx_addr/tx_last held stable; no bubble insertion by this block.
- Outputs tx_vld, tx_data, tx_last, tx_addr driven from registers/state; tx_data via byte-mux on tx_addr is acceptable (no combinational path from tx_rdy).

## Structure
- Shared package eth_pkg: ethertype 16'h0800, IP proto 8'h11, IHL/version 8'h45, TTL 8'h40, header offsets (ETH_HDR=14, IP_HDR=20, UDP_HDR=8, PAYLOAD_OFS=42, FRAME_LEN=46), state enum indices; reused by the RX path.
- Sub-module ip_csum: ones-complement 16-bit accumulator (clear, add-valid, word in, checksum out); reused for later header generation.

## Test plan
- Default params, ID 0, payload 01020304, tx_rdy=1 -> 46 bytes, 24-25 = f5 76, 18-19 = 00 00, 42-45 = 01 02 03 04, tx_last at addr 45, done one cycle later.
- Two back-to-back requests -> second frame ID 00 01, csum f5 75; ack at N+58 after first ack at N.
- tx_rdy toggling 1-0-1 plus 5-cycle stall at addr 20 -> byte stream identical to the no-stall case, each byte held while stalled.
- req pulsed during SEND -> no ack, no frame corruption; held req accepted right after DONE.
- reset_n low at addr 30 -> tx_vld 0 next cycle, no done; subsequent frame starts at addr 0 with ID unchanged (00 00).
- ip_id forced to ffff -> frame carries ff ff, csum matches recomputed value; next frame ID 00 00.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, TX state encoding and the IPv4 header
// word sequence used for checksum generation. Also used by the RX path.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TTL         = 8'h40;

  localparam int ETH_HDR     = 14;
  localparam int IP_HDR      = 20;
  localparam int UDP_HDR     = 8;
  localparam int PAYLOAD_OFS = ETH_HDR + IP_HDR + UDP_HDR;
  localparam int FRAME_LEN   = 46;
  localparam int PAYLOAD_LEN = FRAME_LEN - PAYLOAD_OFS;
  localparam int CSUM_WORDS  = IP_HDR / 2;

  localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR + UDP_HDR + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN      = 16'(UDP_HDR + PAYLOAD_LEN);

  localparam int ST_IDLE = 0;
  localparam int ST_CSUM = 1;
  localparam int ST_SEND = 2;
  localparam int ST_DONE = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'(1 << ST_IDLE),
    S_CSUM = 4'(1 << ST_CSUM),
    S_SEND = 4'(1 << ST_SEND),
    S_DONE = 4'(1 << ST_DONE)
  } tx_state_e;

  // IPv4 header as 16-bit words, checksum field (word 5) taken as zero.
  function automatic logic [15:0] ip_hdr_word(input logic [3:0]  idx,
                                              input logic [15:0] id,
                                              input logic [31:0] src,
                                              input logic [31:0] dst);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {IP_VER_IHL, 8'h00};
      4'd1:    w = IP_TOTAL_LEN;
      4'd2:    w = id;
      4'd4:    w = {IP_TTL, IP_PROTO_UDP};
      4'd6:    w = src[31:16];
      4'd7:    w = src[15:0];
      4'd8:    w = dst[31:16];
      4'd9:    w = dst[15:0];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ip_csum.sv
// Ones-complement 16-bit accumulator with end-around carry; csum is the
// inverted running sum.
module ip_csum (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        add_vld,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [15:0] sum_q, sum_d;
  logic [16:0] raw;

  always_comb begin
    raw   = {1'b0, sum_q} + {1'b0, word};
    sum_d = sum_q;
    if (clr)          sum_d = '0;
    else if (add_vld) sum_d = raw[15:0] + {15'd0, raw[16]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign csum = ~sum_q;

endmodule

// File: rtl/udp_tx_machine.sv
// Wraps one 32-bit payload word into an Ethernet II / IPv4 / UDP frame
// (bytes 0..45) on the MAC TX byte interface.
module udp_tx_machine
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_HWADDR  = 48'h98_5a_eb_dd_1c_65,
  parameter logic [47:0] DST_HWADDR = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] MY_IP      = 32'hc0a80205,
  parameter logic [31:0] DST_IP     = 32'hc0a80201,
  parameter logic [15:0] MY_PORT    = 16'h4e50,
  parameter logic [15:0] DST_PORT   = 16'h4e50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_udp_req,
  input  logic [31:0] tx_udp_data,
  output logic        tx_udp_ack,
  output logic        tx_udp_done,
  output logic        tx_busy,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        tx_last,
  output logic [10:0] tx_addr,
  output logic [7:0]  tx_data
);

  tx_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] addr_q, addr_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [31:0] payload_q, payload_d;

  logic        csum_clr, csum_add;
  logic [15:0] csum;
  logic        in_send, at_last;
  logic [FRAME_LEN*8-1:0] frame;
  logic [5:0]  byte_sel;

  ip_csum u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (csum_clr),
    .add_vld (csum_add),
    .word    (ip_hdr_word(cnt_q, ip_id_q, MY_IP, DST_IP)),
    .csum    (csum)
  );

  assign in_send = (state_q == S_SEND);
  assign at_last = (addr_q == 11'(FRAME_LEN - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ip_id_d   = ip_id_q;
    payload_d = payload_q;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
    case (state_q)
      S_IDLE: if (tx_udp_req) begin
        payload_d = tx_udp_data;
        csum_clr  = 1'b1;
        cnt_d     = '0;
        state_d   = S_CSUM;
      end
      S_CSUM: begin
        csum_add = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'(CSUM_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: if (tx_rdy) begin
        if (at_last) begin
          addr_d  = '0;
          ip_id_d = ip_id_q + 16'd1;
          state_d = S_DONE;
        end else begin
          addr_d = addr_q + 11'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      ip_id_q   <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ip_id_q   <= ip_id_d;
      payload_q <= payload_d;
    end
  end

  // Whole frame as one vector, byte 0 in the MSBs; tx_addr selects a byte.
  // The accumulator holds the finished sum for the whole SEND phase.
  assign frame = {DST_HWADDR, MY_HWADDR, ETHERTYPE_IPV4,
                  IP_VER_IHL, 8'h00, IP_TOTAL_LEN, ip_id_q, 16'h0000,
                  IP_TTL, IP_PROTO_UDP, csum, MY_IP, DST_IP,
                  MY_PORT, DST_PORT, UDP_LEN, 16'h0000, payload_q};
  assign byte_sel = 6'(FRAME_LEN - 1) - addr_q[5:0];

  assign tx_udp_ack  = reset_n & (state_q == S_IDLE) & tx_udp_req;
  assign tx_udp_done = (state_q == S_DONE);
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_vld      = in_send;
  assign tx_last     = in_send & at_last;
  assign tx_addr     = addr_q;
  assign tx_data     = in_send ? frame[{byte_sel, 3'b000} +: 8] : 8'h00;

endmodule
